// File: rtl/ch1_sweep_freq.sv
// Channel-1 frequency register, 1 MHz period counter and NR10 sweep engine.
// Latency: register writes, counter and sweep state update on the next ajer_2mhz edge;
//          a sweep write-back lands 2+n edges after sweep_tick. copu is a registered pulse.
// Backpressure: none; sweep_tick is dropped while a sweep is running or the channel is dead.
//
// Ports:
//   ajer_2mhz / napu_reset     clock, async active-low reset
//   d, apu_wr, ff13, ff14      CPU write path into the 11-bit frequency register
//   ff10_shift, ff10_neg       NR10 sweep shift amount and direction
//   ch1_restart, sweep_tick    trigger and sweep-period pulses from channel1
//   dyfa_1mhz                  period-counter enable
//   freq, copu, atys           frequency, counter overflow pulse, "no sweep overflow"
//   sweep_busy                 sweep engine not idle
module ch1_sweep_freq #(
    parameter int FREQ_W  = 11,
    parameter int SHIFT_W = 3
) (
    input  logic               ajer_2mhz,
    input  logic               napu_reset,
    input  logic [7:0]         d,
    input  logic               apu_wr,
    input  logic               ff13,
    input  logic               ff14,
    input  logic [SHIFT_W-1:0] ff10_shift,
    input  logic               ff10_neg,
    input  logic               ch1_restart,
    input  logic               sweep_tick,
    input  logic               dyfa_1mhz,
    output logic [FREQ_W-1:0]  freq,
    output logic               copu,
    output logic               atys,
    output logic               sweep_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_CALC  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [FREQ_W-1:0]   freq_q, freq_d;
    logic [FREQ_W-1:0]   shadow_q, shadow_d;
    logic [FREQ_W-1:0]   cnt_q, cnt_d;
    logic [FREQ_W-1:0]   sh_q, sh_d;
    logic [SHIFT_W-1:0]  n_q, n_d;
    logic                copu_q, copu_d;
    logic                atys_q, atys_d;
    logic                pass2_q, pass2_d;
    // Shift amount seen at LOAD was zero: CALC only checks overflow, never writes back.
    logic                zero_q, zero_d;

    // One extra bit so an add carry out of the frequency range is visible.
    logic [FREQ_W:0]     sum;

    always_comb begin
        state_d  = state_q;
        freq_d   = freq_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        n_d      = n_q;
        copu_d   = 1'b0;
        atys_d   = atys_q;
        pass2_d  = pass2_q;
        zero_d   = zero_q;

        // Direction is taken live at CALC, not latched at LOAD.
        if (ff10_neg) begin
            sum = {1'b0, shadow_q} - {1'b0, sh_q};
        end else begin
            sum = {1'b0, shadow_q} + {1'b0, sh_q};
        end

        if (ch1_restart) begin
            // Trigger reloads everything and aborts any sweep in flight. A nonzero
            // shift runs one check-only pass so an immediate overflow kills the channel.
            shadow_d = freq_q;
            cnt_d    = freq_q;
            atys_d   = 1'b1;
            if (ff10_shift != '0) begin
                state_d = ST_LOAD;
                pass2_d = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            // Period counter: counts up to all-ones then reloads from freq,
            // giving a period of (2^FREQ_W - freq) enables.
            if (dyfa_1mhz) begin
                if (cnt_q == {FREQ_W{1'b1}}) begin
                    cnt_d  = freq_q;
                    copu_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + FREQ_W'(1);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (sweep_tick && atys_q) begin
                        state_d = ST_LOAD;
                        pass2_d = 1'b0;
                    end
                end
                ST_LOAD: begin
                    sh_d   = shadow_q;
                    n_d    = ff10_shift;
                    zero_d = (ff10_shift == '0);
                    if (ff10_shift != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
                ST_SHIFT: begin
                    // One bit per edge; leaves after n edges.
                    sh_d = sh_q >> 1;
                    n_d  = n_q - SHIFT_W'(1);
                    if (n_q == SHIFT_W'(1)) begin
                        state_d = ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (!ff10_neg && sum[FREQ_W]) begin
                        atys_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (pass2_q || zero_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Commit, then run a second pass purely as an overflow look-ahead.
                        shadow_d = sum[FREQ_W-1:0];
                        freq_d   = sum[FREQ_W-1:0];
                        pass2_d  = 1'b1;
                        state_d  = ST_LOAD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // CPU writes are applied last so they take precedence over a sweep write-back
        // on the same edge; the shadow copy still keeps the swept value.
        if (apu_wr && ff13) begin
            freq_d[7:0] = d;
        end
        if (apu_wr && ff14) begin
            freq_d[FREQ_W-1:8] = d[FREQ_W-9:0];
        end
    end

    always_ff @(posedge ajer_2mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            state_q  <= ST_IDLE;
            freq_q   <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
            n_q      <= '0;
            copu_q   <= 1'b0;
            atys_q   <= 1'b1;
            pass2_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            n_q      <= n_d;
            copu_q   <= copu_d;
            atys_q   <= atys_d;
            pass2_q  <= pass2_d;
            zero_q   <= zero_d;
        end
    end

    assign freq       = freq_q;
    assign copu       = copu_q;
    assign atys       = atys_q;
    assign sweep_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ch1_sweep_freq.sv
// Directed bench for ch1_sweep_freq: per-cycle vector table for sweeps,
// plus hand sequences for trigger/CPU collisions, period counter and async reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_ch1_sweep_freq;

    logic        clk;
    logic        rst_n;
    logic [7:0]  d;
    logic        apu_wr;
    logic        ff13;
    logic        ff14;
    logic [2:0]  ff10_shift;
    logic        ff10_neg;
    logic        ch1_restart;
    logic        sweep_tick;
    logic        dyfa_1mhz;
    logic [10:0] freq;
    logic        copu;
    logic        atys;
    logic        sweep_busy;

    int n_cmp;
    int n_bad;

    ch1_sweep_freq #(.FREQ_W(11), .SHIFT_W(3)) dut (
        .ajer_2mhz  (clk),
        .napu_reset (rst_n),
        .d          (d),
        .apu_wr     (apu_wr),
        .ff13       (ff13),
        .ff14       (ff14),
        .ff10_shift (ff10_shift),
        .ff10_neg   (ff10_neg),
        .ch1_restart(ch1_restart),
        .sweep_tick (sweep_tick),
        .dyfa_1mhz  (dyfa_1mhz),
        .freq       (freq),
        .copu       (copu),
        .atys       (atys),
        .sweep_busy (sweep_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w13;
        logic        w14;
        logic [7:0]  dat;
        logic [2:0]  sh;
        logic        neg;
        logic        rst;
        logic        tick;
        logic [10:0] e_freq;
        logic        e_atys;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic w13, input logic w14, input logic [7:0] dat,
                       input logic [2:0] sh, input logic neg, input logic rst,
                       input logic tick, input logic [10:0] e_freq,
                       input logic e_atys, input logic e_busy);
        vec_t v;
        v.w13 = w13; v.w14 = w14; v.dat = dat; v.sh = sh; v.neg = neg;
        v.rst = rst; v.tick = tick; v.e_freq = e_freq; v.e_atys = e_atys;
        v.e_busy = e_busy;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        apu_wr = 1'b0; ff13 = 1'b0; ff14 = 1'b0; d = 8'h00;
        ch1_restart = 1'b0; sweep_tick = 1'b0;
    endtask

    task automatic wr_reg(input logic is13, input logic [7:0] v);
        apu_wr = 1'b1; ff13 = is13; ff14 = ~is13; d = v;
        step();
        quiet();
    endtask

    task automatic pulse_restart();
        ch1_restart = 1'b1;
        step();
        ch1_restart = 1'b0;
    endtask

    task automatic pulse_tick();
        sweep_tick = 1'b1;
        step();
        sweep_tick = 1'b0;
    endtask

    // Count edges until copu is seen, bounded; returns 0 on timeout.
    task automatic edges_to_copu(output int n);
        n = 0;
        for (int i = 1; i <= 3000; i++) begin
            step();
            if (copu === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int cnt;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        quiet();
        ff10_shift = 3'd0; ff10_neg = 1'b0; dyfa_1mhz = 1'b0;
        #12;
        chk("reset freq", 32'(freq), 32'h000);
        chk("reset atys", 32'(atys), 32'd1);
        chk("reset copu", 32'(copu), 32'd0);
        chk("reset busy", 32'(sweep_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ---- add sweep 0x100, shift 1 ----
        row(1,0,8'h00,3'd1,0,0,0, 11'h000,1,0);
        row(0,1,8'h01,3'd1,0,0,0, 11'h100,1,0);
        row(0,0,8'h00,3'd1,0,1,0, 11'h100,1,1);   // trigger -> LOAD (check pass)
        row(0,0,8'h00,3'd1,0,0,0, 11'h100,1,1);
        row(0,0,8'h00,3'd1,0,0,0, 11'h100,1,1);
        row(0,0,8'h00,3'd1,0,0,0, 11'h100,1,0);   // 0x180 fits, no write
        row(0,0,8'h00,3'd1,0,0,1, 11'h100,1,1);   // tick, edge k
        row(0,0,8'h00,3'd1,0,0,0, 11'h100,1,1);
        row(0,0,8'h00,3'd1,0,0,0, 11'h100,1,1);
        row(0,0,8'h00,3'd1,0,0,0, 11'h180,1,1);   // k+3 write-back
        row(0,0,8'h00,3'd1,0,0,0, 11'h180,1,1);
        row(0,0,8'h00,3'd1,0,0,0, 11'h180,1,1);
        row(0,0,8'h00,3'd1,0,0,0, 11'h180,1,0);   // k+6 second pass 0x240 ok
        // ---- overflow 0x400, shift 1 ----
        row(1,0,8'h00,3'd1,0,0,0, 11'h100,1,0);
        row(0,1,8'h04,3'd1,0,0,0, 11'h400,1,0);
        row(0,0,8'h00,3'd1,0,1,0, 11'h400,1,1);
        row(0,0,8'h00,3'd1,0,0,0, 11'h400,1,1);
        row(0,0,8'h00,3'd1,0,0,0, 11'h400,1,1);
        row(0,0,8'h00,3'd1,0,0,0, 11'h400,1,0);   // 0x600 fits
        row(0,0,8'h00,3'd1,0,0,1, 11'h400,1,1);
        row(0,0,8'h00,3'd1,0,0,0, 11'h400,1,1);
        row(0,0,8'h00,3'd1,0,0,0, 11'h400,1,1);
        row(0,0,8'h00,3'd1,0,0,0, 11'h600,1,1);
        row(0,0,8'h00,3'd1,0,0,0, 11'h600,1,1);
        row(0,0,8'h00,3'd1,0,0,0, 11'h600,1,1);
        row(0,0,8'h00,3'd1,0,0,0, 11'h600,0,0);   // 0x900 overflows
        row(0,0,8'h00,3'd1,0,0,1, 11'h600,0,0);   // tick ignored while dead
        row(0,0,8'h00,3'd1,0,0,0, 11'h600,0,0);
        // ---- subtract 0x400, shift 2 ----
        row(0,1,8'h04,3'd2,1,0,0, 11'h400,0,0);
        row(0,0,8'h00,3'd2,1,1,0, 11'h400,1,1);   // trigger revives atys
        row(0,0,8'h00,3'd2,1,0,0, 11'h400,1,1);
        row(0,0,8'h00,3'd2,1,0,0, 11'h400,1,1);
        row(0,0,8'h00,3'd2,1,0,0, 11'h400,1,1);
        row(0,0,8'h00,3'd2,1,0,0, 11'h400,1,0);
        row(0,0,8'h00,3'd2,1,0,1, 11'h400,1,1);   // k
        row(0,0,8'h00,3'd2,1,0,0, 11'h400,1,1);
        row(0,0,8'h00,3'd2,1,0,0, 11'h400,1,1);
        row(0,0,8'h00,3'd2,1,0,0, 11'h400,1,1);
        row(0,0,8'h00,3'd2,1,0,0, 11'h300,1,1);   // k+4
        row(0,0,8'h00,3'd2,1,0,0, 11'h300,1,1);
        row(0,0,8'h00,3'd2,1,0,0, 11'h300,1,1);
        row(0,0,8'h00,3'd2,1,0,0, 11'h300,1,1);
        row(0,0,8'h00,3'd2,1,0,0, 11'h300,1,0);   // k+8
        // ---- zero shift, add 0x400+0x400 ----
        row(0,1,8'h04,3'd0,0,0,0, 11'h400,1,0);
        row(0,0,8'h00,3'd0,0,1,0, 11'h400,1,0);   // trigger with shift 0 stays idle
        row(0,0,8'h00,3'd0,0,0,1, 11'h400,1,1);
        row(0,0,8'h00,3'd0,0,0,0, 11'h400,1,1);
        row(0,0,8'h00,3'd0,0,0,0, 11'h400,0,0);   // 0x800 overflows, freq unchanged

        for (int i = 0; i < tbl.size(); i++) begin
            apu_wr      = tbl[i].w13 | tbl[i].w14;
            ff13        = tbl[i].w13;
            ff14        = tbl[i].w14;
            d           = tbl[i].dat;
            ff10_shift  = tbl[i].sh;
            ff10_neg    = tbl[i].neg;
            ch1_restart = tbl[i].rst;
            sweep_tick  = tbl[i].tick;
            step();
            chk($sformatf("vec%0d freq", i), 32'(freq), 32'(tbl[i].e_freq));
            chk($sformatf("vec%0d atys", i), 32'(atys), 32'(tbl[i].e_atys));
            chk($sformatf("vec%0d busy", i), 32'(sweep_busy), 32'(tbl[i].e_busy));
            chk($sformatf("vec%0d copu", i), 32'(copu), 32'd0);
        end
        quiet();

        // ---- trigger during SHIFT aborts and reloads shadow ----
        ff10_shift = 3'd2; ff10_neg = 1'b0;
        wr_reg(1'b1, 8'h00);
        wr_reg(1'b0, 8'h01);                       // freq 0x100
        pulse_restart();
        for (int i = 0; i < 4; i++) step();
        chk("abort pre idle", 32'(sweep_busy), 32'd0);
        wr_reg(1'b0, 8'h02);                       // freq 0x200, shadow stays 0x100
        pulse_tick();                              // k: LOAD
        step();                                    // k+1: SHIFT
        pulse_restart();                           // k+2: abort, shadow <= 0x200
        chk("abort busy", 32'(sweep_busy), 32'd1);
        chk("abort atys", 32'(atys), 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("abort freq", 32'(freq), 32'h200);
        chk("abort done", 32'(sweep_busy), 32'd0);

        // ---- CPU NR13 write on the CALC edge wins ----
        ff10_shift = 3'd1;
        wr_reg(1'b0, 8'h01);                       // freq 0x100
        pulse_restart();
        for (int i = 0; i < 3; i++) step();
        pulse_tick();                              // k
        step();                                    // k+1
        step();                                    // k+2
        apu_wr = 1'b1; ff13 = 1'b1; d = 8'h55;
        step();                                    // k+3 CALC edge
        quiet();
        chk("collide freq", 32'(freq), 32'h155);
        chk("collide busy", 32'(sweep_busy), 32'd1);
        for (int i = 0; i < 3; i++) step();
        chk("collide done", 32'(sweep_busy), 32'd0);
        chk("collide keep", 32'(freq), 32'h155);

        // ---- period counter, freq 0x7FE ----
        ff10_shift = 3'd0;
        wr_reg(1'b1, 8'hFE);
        wr_reg(1'b0, 8'h07);
        dyfa_1mhz = 1'b1;
        pulse_restart();
        chk("per7fe trig", 32'(copu), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("per7fe e%0d", i + 1), 32'(copu), 32'(i % 2));
        end

        // ---- period counter, freq 0x000 ----
        dyfa_1mhz = 1'b0;
        wr_reg(1'b1, 8'h00);
        wr_reg(1'b0, 8'h00);
        dyfa_1mhz = 1'b1;
        pulse_restart();
        edges_to_copu(cnt);
        chk("per000 first", 32'(cnt), 32'd2048);
        edges_to_copu(cnt);
        chk("per000 second", 32'(cnt), 32'd2048);

        // ---- async reset mid-sweep ----
        dyfa_1mhz = 1'b0;
        ff10_shift = 3'd2;
        wr_reg(1'b0, 8'h01);
        pulse_restart();                           // LOAD
        step();                                    // SHIFT
        chk("pre-reset busy", 32'(sweep_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst freq", 32'(freq), 32'h000);
        chk("arst atys", 32'(atys), 32'd1);
        chk("arst copu", 32'(copu), 32'd0);
        chk("arst busy", 32'(sweep_busy), 32'd0);
        ff10_shift = 3'd0;
        dyfa_1mhz = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2047; i++) begin
            step();
            if (copu === 1'b1) cnt++;
        end
        chk("post-reset quiet", 32'(cnt), 32'd0);
        step();
        chk("post-reset 2048", 32'(copu), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
